mfcc_frame_scheduler: RTL and testbench
=======================================

MFCC_FRAME_SCHEDULER -- requirements
Module: mfcc_frame_scheduler

Interface
REQ-001 Parameter FRAME_SIZE, default 306, samples per analysis frame.
REQ-002 Parameter FRAME_MOVE, default 123, new samples required per subsequent frame (hop).
REQ-003 Parameter PCM_FIFO_DEPTH, default 256, capacity of the upstream PCM FIFO, in samples.
REQ-004 Parameter CNT_W, default 10, width of the sample-credit counter; CNT_W SHALL be at least clog2(FRAME_SIZE+1).
REQ-005 clk  in  1  single clock; all logic SHALL be on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable_i  in  1  when high, allows new frames to be started.
REQ-008 sample_valid_i  in  1  one pre-emphasized sample was written to the PCM FIFO this cycle.
REQ-009 load_done_i  in  1  one-cycle pulse: the window buffer has finished loading or shifting the frame.
REQ-010 hamming_done_i  in  1  one-cycle pulse: the Hamming stage has finished the frame.
REQ-011 fft_done_i  in  1  one-cycle pulse: the FFT/back-end has consumed the frame.
REQ-012 load_start_o  out  1  one-cycle pulse that starts the window-buffer load or shift.
REQ-013 hamming_start_o  out  1  one-cycle pulse that starts the Hamming window.
REQ-014 fft_start_o  out  1  one-cycle pulse that starts the FFT.
REQ-015 first_frame_o  out  1  high when the pending or active load is a full FRAME_SIZE fill.
REQ-016 busy_o  out  1  high in any state other than IDLE and FILL.
REQ-017 credit_o  out  CNT_W  samples available but not yet committed to a frame.
REQ-018 frame_count_o  out  16  number of frames completed; wraps modulo 2^16.
REQ-019 overrun_o  out  1  sticky flag: credit exceeded PCM_FIFO_DEPTH.

Function
REQ-020 State set: IDLE, FILL, LOAD, HAMMING, FFT. Encoding is free.
REQ-021 IDLE -> FILL when enable_i=1.
REQ-022 FILL -> LOAD when credit >= need. need = FRAME_SIZE if first_frame_o=1, else FRAME_MOVE.
REQ-023 LOAD -> HAMMING on load_done_i.
REQ-024 HAMMING -> FFT on hamming_done_i.
REQ-025 FFT -> FILL on fft_done_i when enable_i=1; FFT -> IDLE on fft_done_i when enable_i=0.
REQ-026 FILL with enable_i=0 SHALL go to IDLE; first_frame_o SHALL then be set.
REQ-027 Start pulses are registered, not combinational.
  - The edge that performs the FILL->LOAD transition SHALL drive load_start_o=1 for the next cycle only.
  - LOAD->HAMMING SHALL likewise drive hamming_start_o; HAMMING->FFT SHALL likewise drive fft_start_o.
REQ-028 At most one start pulse SHALL be high in any cycle.
REQ-029 Credit update on each edge: credit <= credit + sample_valid_i - (need if FILL->LOAD taken, else 0).
  - A simultaneous increment and decrement SHALL be applied together (net update).
REQ-030 Credit SHALL count samples arriving in every state, including IDLE.
REQ-031 If sample_valid_i=1 while credit >= PCM_FIFO_DEPTH and no decrement occurs that edge:
  - credit SHALL saturate (hold);
  - overrun_o SHALL set and stay set until reset.
REQ-032 first_frame_o SHALL clear on the FILL->LOAD transition.
REQ-033 frame_count_o SHALL increment on every fft_done_i accepted in state FFT.
REQ-034 Done inputs received outside their own state (load_done_i outside LOAD, hamming_done_i outside HAMMING, fft_done_i outside FFT) SHALL be ignored.
REQ-035 No timeout: LOAD, HAMMING and FFT SHALL wait indefinitely for their done input.

Reset
REQ-036 With rst=1 at an edge, the block SHALL go to IDLE, with:
  - credit_o=0, frame_count_o=0;
  - all start pulses, busy_o and overrun_o at 0;
  - first_frame_o=1.
REQ-037 Reset SHALL take priority over all other inputs, including mid-frame.
REQ-038 After reset, late done pulses from the aborted frame SHALL have no effect.

Verification
REQ-039 Enable=1, 306 samples at 1/cycle, each done returned 3 cycles after its start -> load_start_o one cycle after the 306th sample edge; then hamming_start_o, then fft_start_o; credit_o=0; frame_count_o=1.
REQ-040 Continue with 123 samples after frame 1 -> second load_start_o with first_frame_o=0; credit_o returns to 0; frame_count_o=2.
REQ-041 Stall: fft_done_i withheld while 300 samples arrive -> credit_o=256 and holds; overrun_o=1; on fft_done_i, FILL->LOAD occurs immediately and credit becomes 133.
REQ-042 sample_valid_i=1 on the same edge as FILL->LOAD, with credit=123 on the non-first frame -> credit_o=1.
REQ-043 rst pulsed while in HAMMING, then hamming_done_i sent -> block stays in IDLE with no pulses; reset values hold.
REQ-044 enable_i dropped during FFT -> after fft_done_i the block goes to IDLE; re-enabling with credit=200 does not start a frame until credit reaches 306 (first_frame_o=1).

Source files
------------

// File: rtl/mfcc_frame_scheduler.sv
// Sequences one MFCC analysis frame at a time: waits for enough PCM samples,
// then steps the window-buffer load, Hamming and FFT stages by start/done handshakes.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | disabled; samples still counted, next frame is a full fill
//   S_FILL    | waiting for credit to reach FRAME_SIZE (first) or FRAME_MOVE
//   S_LOAD    | window buffer loading/shifting, waiting for load_done_i
//   S_HAMMING | Hamming window running, waiting for hamming_done_i
//   S_FFT     | FFT/back-end running, waiting for fft_done_i
module mfcc_frame_scheduler #(
    parameter int FRAME_SIZE     = 306,
    parameter int FRAME_MOVE     = 123,
    parameter int PCM_FIFO_DEPTH = 256,
    parameter int CNT_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             sample_valid_i,
    input  logic             load_done_i,
    input  logic             hamming_done_i,
    input  logic             fft_done_i,
    output logic             load_start_o,
    output logic             hamming_start_o,
    output logic             fft_start_o,
    output logic             first_frame_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] credit_o,
    output logic [15:0]      frame_count_o,
    output logic             overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_HAMMING,
        S_FFT
    } state_t;

    // A full first fill is streamed into the window buffer while it arrives,
    // so the credit ceiling for that frame is the larger of frame and FIFO size.
    localparam int CEIL_FIRST = (FRAME_SIZE > PCM_FIFO_DEPTH) ? FRAME_SIZE : PCM_FIFO_DEPTH;

    localparam logic [CNT_W-1:0] SIZE_C       = CNT_W'(FRAME_SIZE);
    localparam logic [CNT_W-1:0] MOVE_C       = CNT_W'(FRAME_MOVE);
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(PCM_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CEIL_FIRST_C = CNT_W'(CEIL_FIRST);

    state_t           state_q;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic [15:0]      frame_count_q;
    logic             first_frame_q;
    logic             overrun_q;
    logic             load_start_q, hamming_start_q, fft_start_q;

    logic [CNT_W-1:0] need;
    logic [CNT_W-1:0] ceiling;
    logic             take_frame;
    logic             saturate;

    always_comb begin
        need       = first_frame_q ? SIZE_C : MOVE_C;
        ceiling    = first_frame_q ? CEIL_FIRST_C : DEPTH_C;
        take_frame = (state_q == S_FILL) && enable_i && (credit_q >= need);
        saturate   = sample_valid_i && !take_frame && (credit_q >= ceiling);
        credit_d   = credit_q;
        if (take_frame) begin
            credit_d = credit_q - need + CNT_W'(sample_valid_i);
        end else if (!saturate) begin
            credit_d = credit_q + CNT_W'(sample_valid_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            credit_q        <= '0;
            frame_count_q   <= '0;
            first_frame_q   <= 1'b1;
            overrun_q       <= 1'b0;
            load_start_q    <= 1'b0;
            hamming_start_q <= 1'b0;
            fft_start_q     <= 1'b0;
        end else begin
            load_start_q    <= 1'b0;
            hamming_start_q <= 1'b0;
            fft_start_q     <= 1'b0;
            credit_q        <= credit_d;
            if (saturate) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!enable_i) begin
                        state_q       <= S_IDLE;
                        first_frame_q <= 1'b1;
                    end else if (take_frame) begin
                        state_q       <= S_LOAD;
                        load_start_q  <= 1'b1;
                        first_frame_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_done_i) begin
                        state_q         <= S_HAMMING;
                        hamming_start_q <= 1'b1;
                    end
                end
                S_HAMMING: begin
                    if (hamming_done_i) begin
                        state_q     <= S_FFT;
                        fft_start_q <= 1'b1;
                    end
                end
                S_FFT: begin
                    if (fft_done_i) begin
                        frame_count_q <= frame_count_q + 16'd1;
                        if (enable_i) begin
                            state_q <= S_FILL;
                        end else begin
                            // window contents go stale while idle, so restart with a full fill
                            state_q       <= S_IDLE;
                            first_frame_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_start_o    = load_start_q;
    assign hamming_start_o = hamming_start_q;
    assign fft_start_o     = fft_start_q;
    assign first_frame_o   = first_frame_q;
    assign busy_o          = (state_q == S_LOAD) || (state_q == S_HAMMING) || (state_q == S_FFT);
    assign credit_o        = credit_q;
    assign frame_count_o   = frame_count_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Self-checking bench for mfcc_frame_scheduler: vector table, directed frame
// sequences and a randomized run, all compared with a frame-level reference model.
module tb_mfcc_frame_scheduler;

    localparam int FS    = 306;
    localparam int FM    = 123;
    localparam int DEPTH = 256;
    localparam int CW    = 10;

    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_LOAD = 2;
    localparam int P_HAM  = 3;
    localparam int P_FFT  = 4;

    logic          clk = 1'b0;
    logic          rst, en, sv, ld, hd, fd;
    logic          load_start_o, hamming_start_o, fft_start_o;
    logic          first_frame_o, busy_o, overrun_o;
    logic [CW-1:0] credit_o;
    logic [15:0]   frame_count_o;

    mfcc_frame_scheduler #(
        .FRAME_SIZE(FS), .FRAME_MOVE(FM), .PCM_FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(en), .sample_valid_i(sv),
        .load_done_i(ld), .hamming_done_i(hd), .fft_done_i(fd),
        .load_start_o(load_start_o), .hamming_start_o(hamming_start_o),
        .fft_start_o(fft_start_o), .first_frame_o(first_frame_o),
        .busy_o(busy_o), .credit_o(credit_o), .frame_count_o(frame_count_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_phase, m_credit, m_fc;
    bit m_first, m_ov, m_ls, m_hs, m_fs;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s,
                              input bit l, input bit h, input bit f);
        int need, ceil_v;
        bit take;
        if (r) begin
            m_phase = P_IDLE; m_credit = 0; m_fc = 0;
            m_first = 1; m_ov = 0; m_ls = 0; m_hs = 0; m_fs = 0;
            return;
        end
        m_ls = 0; m_hs = 0; m_fs = 0;
        need   = m_first ? FS : FM;
        ceil_v = m_first ? ((FS > DEPTH) ? FS : DEPTH) : DEPTH;
        take   = (m_phase == P_FILL) && e && (m_credit >= need);
        if (take)                          m_credit = m_credit - need + int'(s);
        else if (s && m_credit >= ceil_v)  m_ov = 1;
        else                               m_credit = m_credit + int'(s);
        case (m_phase)
            P_IDLE: if (e) m_phase = P_FILL;
            P_FILL: begin
                if (!e) begin m_phase = P_IDLE; m_first = 1; end
                else if (take) begin m_phase = P_LOAD; m_ls = 1; m_first = 0; end
            end
            P_LOAD: if (l) begin m_phase = P_HAM; m_hs = 1; end
            P_HAM:  if (h) begin m_phase = P_FFT; m_fs = 1; end
            default: if (f) begin
                m_fc = (m_fc + 1) % 65536;
                if (e) m_phase = P_FILL;
                else begin m_phase = P_IDLE; m_first = 1; end
            end
        endcase
    endtask

    task automatic tick();
        bit r, e, s, l, h, f;
        r = rst; e = en; s = sv; l = ld; h = hd; f = fd;
        @(posedge clk);
        model_step(r, e, s, l, h, f);
        #1;
        check("model credit", int'(credit_o), m_credit);
        check("model frame_count", int'(frame_count_o), m_fc);
        check("model first_frame", int'(first_frame_o), int'(m_first));
        check("model overrun", int'(overrun_o), int'(m_ov));
        check("model busy", int'(busy_o), int'(m_phase >= P_LOAD));
        check("model load_start", int'(load_start_o), int'(m_ls));
        check("model hamming_start", int'(hamming_start_o), int'(m_hs));
        check("model fft_start", int'(fft_start_o), int'(m_fs));
    endtask

    // done returned on the third edge after the start pulse was seen
    task automatic respond(input int which);
        tick();
        tick();
        case (which)
            0:       ld = 1'b1;
            1:       hd = 1'b1;
            default: fd = 1'b1;
        endcase
        tick();
        ld = 1'b0; hd = 1'b0; fd = 1'b0;
    endtask

    task automatic samples(input int n);
        sv = 1'b1;
        repeat (n) tick();
        sv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit r, e, s, l, h, f;
        int credit;
        bit busy, first, ov;
        int fc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        rst = 1'b1; en = 1'b0; sv = 1'b0; ld = 1'b0; hd = 1'b0; fd = 1'b0;
        m_phase = P_IDLE; m_credit = 0; m_fc = 0;
        m_first = 1; m_ov = 0; m_ls = 0; m_hs = 0; m_fs = 0;

        //        r e s l h f  credit busy first ov fc
        tbl[0] = '{1,0,0,0,0,0, 0, 0, 1, 0, 0};
        tbl[1] = '{0,0,1,0,0,0, 1, 0, 1, 0, 0};
        tbl[2] = '{0,0,1,1,1,1, 2, 0, 1, 0, 0};
        tbl[3] = '{0,1,0,0,0,0, 2, 0, 1, 0, 0};
        tbl[4] = '{0,1,1,0,0,1, 3, 0, 1, 0, 0};
        tbl[5] = '{0,0,0,1,0,0, 3, 0, 1, 0, 0};
        tbl[6] = '{1,0,1,0,0,0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].r; en = tbl[i].e; sv = tbl[i].s;
            ld = tbl[i].l; hd = tbl[i].h; fd = tbl[i].f;
            tick();
            check("tbl credit", int'(credit_o), tbl[i].credit);
            check("tbl busy", int'(busy_o), int'(tbl[i].busy));
            check("tbl first_frame", int'(first_frame_o), int'(tbl[i].first));
            check("tbl overrun", int'(overrun_o), int'(tbl[i].ov));
            check("tbl frame_count", int'(frame_count_o), tbl[i].fc);
            check("tbl pulses", int'(load_start_o | hamming_start_o | fft_start_o), 0);
        end
        rst = 1'b0; sv = 1'b0; ld = 1'b0; hd = 1'b0; fd = 1'b0;

        // first frame: 306 samples then full start/done chain
        do_reset();
        en = 1'b1;
        samples(FS);
        check("first credit full", int'(credit_o), FS);
        check("first no early load", int'(load_start_o), 0);
        tick();
        check("first load_start", int'(load_start_o), 1);
        check("first credit drained", int'(credit_o), 0);
        respond(0);
        check("first hamming_start", int'(hamming_start_o), 1);
        respond(1);
        check("first fft_start", int'(fft_start_o), 1);
        respond(2);
        check("first frame_count", int'(frame_count_o), 1);

        // second frame needs only the hop
        samples(FM);
        tick();
        check("hop load_start", int'(load_start_o), 1);
        check("hop first_frame", int'(first_frame_o), 0);
        check("hop credit", int'(credit_o), 0);
        respond(0); respond(1); respond(2);
        check("hop frame_count", int'(frame_count_o), 2);

        // stall in FFT with samples flooding in
        samples(FM);
        tick();
        respond(0); respond(1);
        check("stall in fft", int'(fft_start_o), 1);
        samples(300);
        check("stall credit sat", int'(credit_o), DEPTH);
        check("stall overrun", int'(overrun_o), 1);
        repeat (5) tick();
        check("stall credit hold", int'(credit_o), DEPTH);
        fd = 1'b1;
        tick();
        fd = 1'b0;
        check("stall frame_count", int'(frame_count_o), 3);
        tick();
        check("stall load_start", int'(load_start_o), 1);
        check("stall credit after", int'(credit_o), DEPTH - FM);
        respond(0); respond(1); respond(2);

        // simultaneous increment and decrement
        do_reset();
        en = 1'b1;
        samples(FS);
        tick();
        respond(0); respond(1); respond(2);
        sv = 1'b1;
        repeat (FM) tick();
        check("net credit before", int'(credit_o), FM);
        tick();
        sv = 1'b0;
        check("net load_start", int'(load_start_o), 1);
        check("net credit", int'(credit_o), 1);

        // reset in HAMMING, then a stale done
        respond(0);
        check("abort in hamming", int'(hamming_start_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0; hd = 1'b1;
        tick();
        hd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort no pulses", int'(load_start_o | hamming_start_o | fft_start_o), 0);
        end
        check("abort busy", int'(busy_o), 0);
        check("abort credit", int'(credit_o), 0);
        check("abort frame_count", int'(frame_count_o), 0);
        check("abort first_frame", int'(first_frame_o), 1);

        // disable during FFT, re-enable needs a full frame again
        do_reset();
        en = 1'b1;
        samples(FS);
        tick();
        respond(0); respond(1);
        en = 1'b0;
        respond(2);
        check("dis busy", int'(busy_o), 0);
        check("dis frame_count", int'(frame_count_o), 1);
        samples(200);
        en = 1'b1;
        repeat (4) tick();
        check("reen no load", int'(load_start_o), 0);
        check("reen first_frame", int'(first_frame_o), 1);
        check("reen credit", int'(credit_o), 200);
        samples(FS - 200);
        check("reen credit full", int'(credit_o), FS);
        check("reen still waiting", int'(load_start_o), 0);
        tick();
        check("reen load_start", int'(load_start_o), 1);
        check("reen credit drained", int'(credit_o), 0);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            en  = ($urandom_range(0, 24) != 0);
            sv  = (i % 2000 < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 6) == 0);
            hd  = ($urandom_range(0, 6) == 0);
            fd  = ($urandom_range(0, 6) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
